// File: rtl/led_strand_driver_if.sv
// -----------------------------------------------------------------------------
// led_strand_driver_if
// Pattern request/response bundle between a colour source and the strand
// driver. The driver (master) publishes the index of the LED it wants next;
// the pattern generator (slave) answers with that LED's colour and raises
// color_valid_in while the colour matches the published index.
//
// Signals:
//   next_led_request  IDX_WIDTH    index of the LED whose colour is wanted
//   red_in            COLOR_WIDTH  red channel of the response
//   green_in          COLOR_WIDTH  green channel of the response
//   blue_in           COLOR_WIDTH  blue channel of the response
//   color_valid_in    1            response matches next_led_request
// -----------------------------------------------------------------------------
interface led_strand_driver_if #(
    parameter int COLOR_WIDTH = 8,
    parameter int IDX_WIDTH   = 5
);
    logic [IDX_WIDTH-1:0]   next_led_request;
    logic [COLOR_WIDTH-1:0] red_in;
    logic [COLOR_WIDTH-1:0] green_in;
    logic [COLOR_WIDTH-1:0] blue_in;
    logic                   color_valid_in;

    // Strand driver side: issues requests, consumes colours.
    modport master (
        output next_led_request,
        input  red_in,
        input  green_in,
        input  blue_in,
        input  color_valid_in
    );

    // Pattern generator side: observes requests, supplies colours.
    modport slave (
        input  next_led_request,
        output red_in,
        output green_in,
        output blue_in,
        output color_valid_in
    );
endinterface

// File: rtl/led_strand_driver.sv
// -----------------------------------------------------------------------------
// led_strand_driver
// Fetches one colour per LED from a pattern generator and serialises it as a
// WS2812-style one-wire bitstream (GRB order, MSB of green first). After the
// last LED of a frame the line is held low for the latch period and a one
// cycle frame_done_out pulse is emitted.
//
// Ports:
//   clk_in          in   1   system clock
//   rst_in          in   1   asynchronous active-low reset
//   enable_in       in   1   frames start only while high (sampled in IDLE
//                            and at the end of LATCH)
//   pat             if   -   request/response bundle (master modport)
//   strand_out      out  1   serial data to the strand
//   busy_out        out  1   high in any state other than IDLE
//   frame_done_out  out  1   one-cycle pulse on the final LATCH cycle
//
// All outputs are registered. Their next values are derived from the
// next-state logic so that each output lines up with the state it belongs to:
// strand_out is high exactly while the FSM sits in SEND_HIGH.
// -----------------------------------------------------------------------------
module led_strand_driver #(
    parameter int NUM_LEDS     = 20,
    parameter int COLOR_WIDTH  = 8,
    parameter int T0H_CYCLES   = 35,
    parameter int T0L_CYCLES   = 80,
    parameter int T1H_CYCLES   = 70,
    parameter int T1L_CYCLES   = 55,
    parameter int LATCH_CYCLES = 5000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    led_strand_driver_if.master   pat,
    output logic                  strand_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    // A single LED still needs a 1-bit index register (held at 0).
    localparam int CounterWidth = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BitsPerLed   = 3 * COLOR_WIDTH;
    localparam int BitCntWidth  = (BitsPerLed > 1) ? $clog2(BitsPerLed) : 1;

    localparam int MaxHigh      = (T0H_CYCLES > T1H_CYCLES) ? T0H_CYCLES : T1H_CYCLES;
    localparam int MaxLow       = (T0L_CYCLES > T1L_CYCLES) ? T0L_CYCLES : T1L_CYCLES;
    localparam int MaxBit       = (MaxHigh > MaxLow) ? MaxHigh : MaxLow;
    localparam int MaxCycles    = (LATCH_CYCLES > MaxBit) ? LATCH_CYCLES : MaxBit;
    localparam int TimerWidth   = $clog2(MaxCycles + 1);

    // Timer reload values: N-1 so that a state lasts exactly N cycles.
    localparam logic [TimerWidth-1:0]  T0H_LOAD   = TimerWidth'(T0H_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  T0L_LOAD   = TimerWidth'(T0L_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  T1H_LOAD   = TimerWidth'(T1H_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  T1L_LOAD   = TimerWidth'(T1L_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  LATCH_LOAD = TimerWidth'(LATCH_CYCLES - 1);
    localparam logic [TimerWidth-1:0]  TimerZero  = TimerWidth'(0);
    localparam logic [TimerWidth-1:0]  TimerOne   = TimerWidth'(1);

    localparam logic [CounterWidth-1:0] LastLed   = CounterWidth'(NUM_LEDS - 1);
    localparam logic [CounterWidth-1:0] IdxZero   = CounterWidth'(0);
    localparam logic [CounterWidth-1:0] IdxOne    = CounterWidth'(1);

    localparam logic [BitCntWidth-1:0]  LastBit   = BitCntWidth'(BitsPerLed - 1);
    localparam logic [BitCntWidth-1:0]  BitZero   = BitCntWidth'(0);
    localparam logic [BitCntWidth-1:0]  BitOne    = BitCntWidth'(1);

    localparam logic [BitsPerLed-1:0]   ShiftZero = BitsPerLed'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        SEND_HIGH = 3'd2,
        SEND_LOW  = 3'd3,
        LATCH     = 3'd4
    } state_t;

    state_t                  state_q,   state_d;
    logic [BitsPerLed-1:0]   shift_q,   shift_d;
    logic [BitCntWidth-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TimerWidth-1:0]   timer_q,   timer_d;
    logic [CounterWidth-1:0] idx_q,     idx_d;
    logic                    strand_q,  strand_d;
    logic                    busy_q,    busy_d;
    logic                    done_q,    done_d;
    logic                    timer_zero_s;

    // High-phase duration for a bit of the given value.
    function automatic logic [TimerWidth-1:0] high_load(input logic bit_val);
        if (bit_val) begin
            return T1H_LOAD;
        end else begin
            return T0H_LOAD;
        end
    endfunction

    // Low-phase duration for a bit of the given value.
    function automatic logic [TimerWidth-1:0] low_load(input logic bit_val);
        if (bit_val) begin
            return T1L_LOAD;
        end else begin
            return T0L_LOAD;
        end
    endfunction

    assign timer_zero_s = (timer_q == TimerZero);

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        idx_d     = idx_q;

        case (state_q)
            IDLE: begin
                idx_d = IdxZero;
                if (enable_in) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end

            FETCH: begin
                if (pat.color_valid_in) begin
                    shift_d   = {pat.green_in, pat.red_in, pat.blue_in};
                    bit_cnt_d = BitZero;
                    timer_d   = high_load(pat.green_in[COLOR_WIDTH-1]);
                    state_d   = SEND_HIGH;
                end else begin
                    state_d   = FETCH;
                end
            end

            SEND_HIGH: begin
                if (timer_zero_s) begin
                    timer_d = low_load(shift_q[BitsPerLed-1]);
                    state_d = SEND_LOW;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end

            SEND_LOW: begin
                if (timer_zero_s) begin
                    if (bit_cnt_q != LastBit) begin
                        // The bit just below the MSB becomes the next MSB.
                        shift_d   = {shift_q[BitsPerLed-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BitOne;
                        timer_d   = high_load(shift_q[BitsPerLed-2]);
                        state_d   = SEND_HIGH;
                    end else if (idx_q == LastLed) begin
                        timer_d   = LATCH_LOAD;
                        state_d   = LATCH;
                    end else begin
                        idx_d     = idx_q + IdxOne;
                        state_d   = FETCH;
                    end
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end

            LATCH: begin
                if (timer_zero_s) begin
                    idx_d = IdxZero;
                    if (enable_in) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end

            default: begin
                idx_d   = IdxZero;
                timer_d = TimerZero;
                state_d = IDLE;
            end
        endcase

        // Outputs follow the upcoming state so they align with it once registered.
        strand_d = (state_d == SEND_HIGH);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == LATCH) && (timer_d == TimerZero);
    end

    // State, datapath and output registers; reset drops the line low at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            shift_q   <= ShiftZero;
            bit_cnt_q <= BitZero;
            timer_q   <= TimerZero;
            idx_q     <= IdxZero;
            strand_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            strand_q  <= strand_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pat.next_led_request = idx_q;
    assign strand_out           = strand_q;
    assign busy_out             = busy_q;
    assign frame_done_out       = done_q;

endmodule

// File: tb/tb_led_strand_driver.sv
// -----------------------------------------------------------------------------
// tb_led_strand_driver
// Scoreboard bench: the expected 24-bit GRB word of every LED is queued when
// a frame is launched; a line decoder rebuilds words from strand_out pulse
// widths, checks every high/low time and pops/compares against the queue.
// A responder model answers requests with 1-cycle latency, optionally delays
// LED1 by 10 cycles and optionally injects noise while bits are being sent.
// -----------------------------------------------------------------------------
module tb_led_strand_driver;

    localparam int NUM_LEDS = 2;
    localparam int CW       = 8;
    localparam int IDXW     = 1;
    localparam int T0H      = 35;
    localparam int T0L      = 80;
    localparam int T1H      = 70;
    localparam int T1L      = 55;
    localparam int LATCH    = 5000;
    localparam int FRAME_TO = 20000;

    logic clk_in = 1'b0;
    logic rst_in;
    logic enable_in;
    logic strand_out;
    logic busy_out;
    logic frame_done_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q[$];
    logic [23:0] led_tab [NUM_LEDS];
    bit          delay_mode = 1'b0;
    bit          noise_mode = 1'b0;

    led_strand_driver_if #(.COLOR_WIDTH(CW), .IDX_WIDTH(IDXW)) pat ();

    led_strand_driver #(
        .NUM_LEDS    (NUM_LEDS),
        .COLOR_WIDTH (CW),
        .T0H_CYCLES  (T0H),
        .T0L_CYCLES  (T0L),
        .T1H_CYCLES  (T1H),
        .T1L_CYCLES  (T1L),
        .LATCH_CYCLES(LATCH)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .enable_in     (enable_in),
        .pat           (pat),
        .strand_out    (strand_out),
        .busy_out      (busy_out),
        .frame_done_out(frame_done_out)
    );

    // Free-running 10 ns clock.
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_colour(input logic [23:0] grb, input logic valid);
        pat.green_in       = grb[23:16];
        pat.red_in         = grb[15:8];
        pat.blue_in        = grb[7:0];
        pat.color_valid_in = valid;
    endtask

    // Responder: answers the current request, shortly after each edge.
    initial begin
        logic [IDXW-1:0] prev_req;
        int              wait_cnt;
        prev_req = '0;
        wait_cnt = 0;
        drive_colour(24'h000000, 1'b0);
        forever begin
            @(posedge clk_in);
            #1;
            if (wait_cnt > 0) begin
                wait_cnt--;
                drive_colour(24'($urandom), 1'b0);
                if (rst_in) begin
                    check_val("req_stable", 32'(pat.next_led_request), 32'd1);
                    check_val("low_while_wait", 32'(strand_out), 32'd0);
                end
            end else if (delay_mode && (pat.next_led_request != prev_req) &&
                         (pat.next_led_request == 1'b1)) begin
                wait_cnt = 9;
                drive_colour(24'($urandom), 1'b0);
            end else if (pat.next_led_request != prev_req) begin
                drive_colour(24'($urandom), 1'b0);
            end else if (noise_mode && strand_out) begin
                // Bit in flight: a valid with wrong data must be ignored.
                drive_colour(24'($urandom), 1'b1);
            end else if (noise_mode && ($urandom_range(0, 1) == 0)) begin
                drive_colour(24'($urandom), 1'b0);
            end else begin
                drive_colour(led_tab[pat.next_led_request], 1'b1);
            end
            prev_req = pat.next_led_request;
        end
    end

    // Line decoder: rebuilds LED words from pulse widths and checks timing.
    int          hi_len  = 0;
    int          lo_len  = 0;
    int          bit_idx = 0;
    logic [23:0] word    = 24'h0;
    bit          prev_s  = 1'b0;
    bit          pending = 1'b0;
    bit          last_bit = 1'b0;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            hi_len  = 0;
            lo_len  = 0;
            bit_idx = 0;
            word    = 24'h0;
            prev_s  = 1'b0;
            pending = 1'b0;
        end else begin
            if (strand_out) begin
                if (!prev_s) begin
                    if (pending) begin
                        if (bit_idx != 0) begin
                            check_val("t_low", 32'(lo_len), last_bit ? 32'(T1L) : 32'(T0L));
                        end else begin
                            check_val("t_low_fetch",
                                      32'((lo_len >= (last_bit ? T1L : T0L)) &&
                                          (lo_len <= (last_bit ? T1L : T0L) + 40)), 32'd1);
                        end
                    end
                    pending = 1'b0;
                    hi_len  = 0;
                end
                hi_len++;
            end else begin
                if (prev_s) begin
                    last_bit = (hi_len == T1H);
                    check_val("t_high", 32'(hi_len), last_bit ? 32'(T1H) : 32'(T0H));
                    word    = {word[22:0], last_bit};
                    bit_idx++;
                    pending = 1'b1;
                    lo_len  = 0;
                    if (bit_idx == 24) begin
                        check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) begin
                            check_val("led_word", 32'(word), 32'(exp_q.pop_front()));
                        end
                        bit_idx = 0;
                    end
                end
                lo_len++;
            end
            if (frame_done_out) begin
                check_val("t_frame_low", 32'(lo_len), 32'((last_bit ? T1L : T0L) + LATCH));
                check_val("frame_bits", 32'(bit_idx), 32'd0);
                pending = 1'b0;
            end
            prev_s = strand_out;
        end
    end

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!frame_done_out && (n < limit)) begin
            @(negedge clk_in);
            n++;
        end
        check_val("frame_done_seen", 32'(frame_done_out), 32'd1);
    endtask

    task automatic pulse_enable();
        @(negedge clk_in);
        enable_in = 1'b1;
        @(negedge clk_in);
        enable_in = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk_in);
        check_val(tag, {28'h0, strand_out, busy_out, frame_done_out, pat.next_led_request}, 32'd0);
    endtask

    task automatic push_frame();
        for (int i = 0; i < NUM_LEDS; i++) begin
            exp_q.push_back(led_tab[i]);
        end
    endtask

    // Main sequence.
    initial begin
        int n;
        rst_in    = 1'b0;
        enable_in = 1'b0;
        led_tab[0] = 24'h00FF00;
        led_tab[1] = 24'h0000FF;
        repeat (5) @(negedge clk_in);
        rst_in = 1'b1;

        // Quiet with enable low.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            check_val("idle_quiet",
                      {28'h0, strand_out, busy_out, frame_done_out, pat.next_led_request}, 32'd0);
        end

        // Single frame: red LED then blue LED.
        push_frame();
        pulse_enable();
        check_val("busy_frame", 32'(busy_out), 32'd1);
        wait_done(FRAME_TO);
        check_idle("idle_after_a");

        // Delayed LED1 response plus noise on the response bus while sending.
        led_tab[0] = 24'hA53C81;
        led_tab[1] = 24'h5AC37E;
        delay_mode = 1'b1;
        noise_mode = 1'b1;
        push_frame();
        pulse_enable();
        wait_done(FRAME_TO);
        check_idle("idle_after_b");
        delay_mode = 1'b0;
        noise_mode = 1'b0;

        // Back-to-back frames, enable dropped partway through the second.
        led_tab[0] = 24'h123456;
        led_tab[1] = 24'hFEDCBA;
        push_frame();
        push_frame();
        @(negedge clk_in);
        enable_in = 1'b1;
        wait_done(FRAME_TO);
        @(negedge clk_in);
        check_val("b2b_busy", 32'(busy_out), 32'd1);
        check_val("b2b_req0", 32'(pat.next_led_request), 32'd0);
        check_val("b2b_done_pulse", 32'(frame_done_out), 32'd0);
        repeat (3000) @(negedge clk_in);
        enable_in = 1'b0;
        wait_done(FRAME_TO);
        check_idle("idle_after_b2b");

        // Async reset in the middle of a high phase.
        pulse_enable();
        n = 0;
        while (!strand_out && (n < 100)) begin
            @(negedge clk_in);
            n++;
        end
        check_val("strand_rose", 32'(strand_out), 32'd1);
        repeat (5) @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check_val("rst_strand", 32'(strand_out), 32'd0);
        check_val("rst_busy_req", {30'h0, busy_out, pat.next_led_request}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        rst_in    = 1'b1;
        push_frame();
        enable_in = 1'b1;
        @(negedge clk_in);
        enable_in = 1'b0;
        wait_done(FRAME_TO);
        check_idle("idle_after_rst");

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_strand_driver.md
Name: led_strand_driver

Overview:
- Consumer end of the pattern request/response interface.
- Drives `next_led_request`, waits for `color_valid_in`, latches the returned colour, and serialises it as a WS2812-style one-wire bitstream on `strand_out`.
- One frame covers LEDs 0..NUM_LEDS-1; each frame is followed by a latch/reset low period.
- Sits between any pattern generator and the board pin.

Parameters:
- NUM_LEDS, 20, number of LEDs on the strand.
- COLOR_WIDTH, 8, bits per colour channel; bits per LED = 3*COLOR_WIDTH.
- T0H_CYCLES, 35, high time of a '0' bit, in clk cycles.
- T0L_CYCLES, 80, low time of a '0' bit.
- T1H_CYCLES, 70, high time of a '1' bit.
- T1L_CYCLES, 55, low time of a '1' bit.
- LATCH_CYCLES, 5000, low time after the last LED of a frame.
- CounterWidth (localparam), $clog2(NUM_LEDS), width of the LED index.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous, active-low reset.
- enable_in, input, 1, level; frames start only while high.
- next_led_request, output, CounterWidth, index of the LED whose colour is requested.
- red_in, input, COLOR_WIDTH, colour response.
- green_in, input, COLOR_WIDTH, colour response.
- blue_in, input, COLOR_WIDTH, colour response.
- color_valid_in, input, 1, high when red/green/blue correspond to the current next_led_request.
- strand_out, output, 1, serial data to the LED strand.
- busy_out, output, 1, high in any state except IDLE.
- frame_done_out, output, 1, one-cycle pulse at the end of LATCH.

Behaviour:
- Reset (rst_in low, async):
  - state=IDLE; strand_out=0; next_led_request=0; busy_out=0; frame_done_out=0.
  - Shift register, bit counter, timer and LED index all cleared.
  - Asserting reset mid-bit forces strand_out low immediately.
- All outputs are registered.
- State machine: IDLE, FETCH, SEND_HIGH, SEND_LOW, LATCH.
- IDLE:
  - strand_out=0; next_led_request=0.
  - If enable_in=1, go to FETCH with led index 0.
- FETCH:
  - next_led_request holds the current index; strand_out=0.
  - On a cycle with color_valid_in=1, latch {green_in, red_in, blue_in} (GRB order, MSB of green first) into a 3*COLOR_WIDTH shift register, set bit counter to 0, go to SEND_HIGH.
  - Wait is unbounded; strand_out stays low meanwhile.
  - color_valid_in is ignored outside FETCH.
- SEND_HIGH:
  - strand_out=1 for exactly T1H_CYCLES (if current MSB=1) or T0H_CYCLES (if current MSB=0), then go to SEND_LOW.
- SEND_LOW:
  - strand_out=0 for exactly T1L_CYCLES or T0L_CYCLES, chosen by the same bit.
  - At the end, if bit counter < 3*COLOR_WIDTH-1: shift left, increment the counter, go to SEND_HIGH.
  - Otherwise, if led index = NUM_LEDS-1: go to LATCH.
  - Otherwise: increment the index, update next_led_request, go to FETCH.
- FETCH low-time extension:
  - Time spent in FETCH extends the last bit's low time; a responder with 1-cycle latency adds 2 cycles.
  - This is acceptable while well below LATCH_CYCLES.
- LATCH:
  - strand_out=0 for exactly LATCH_CYCLES.
  - On the final cycle, frame_done_out=1 for one cycle; next_led_request returns to 0.
  - If enable_in=1 go to FETCH (new frame), else go to IDLE.
- enable_in is sampled only in IDLE and at the end of LATCH. Deasserting it mid-frame completes the current frame.
- Timer:
  - Single down-counter of width $clog2(max of the timing parameters + 1).
  - Loaded with N-1 on state entry; state exits when the counter is 0 (exactly N cycles).
- Index wrap: never exceeds NUM_LEDS-1. With NUM_LEDS=1, next_led_request is constant 0.
- Request stability: next_led_request changes only on the SEND_LOW→FETCH and LATCH→FETCH/IDLE transitions, so it is stable throughout each FETCH.

Test Plan:
- Reset and enable_in=0 for 100 cycles -> strand_out=0, busy_out=0, next_led_request=0, frame_done_out=0 throughout.
- NUM_LEDS=2, responder with 1-cycle latency: LED0 = red 0xFF / green 0 / blue 0; LED1 = red 0 / green 0 / blue 0xFF; enable_in pulsed once.
  - Decoded stream is 0x00FF00 then 0x0000FF.
  - '1' bits are 70 cycles high / 55 low; '0' bits are 35 cycles high / 80 low.
  - Then 5000 cycles low, then one frame_done_out pulse, then IDLE.
- Responder delays color_valid_in by 10 cycles for LED1 -> strand_out stays low those extra cycles; next_led_request=1 is stable; no bit lost or duplicated.
- enable_in held high -> back-to-back frames; each frame_done_out is followed by FETCH with next_led_request=0. Dropping enable_in mid-frame -> the frame finishes, then IDLE.
- Async reset asserted in the middle of SEND_HIGH -> strand_out=0 the same cycle without a clock edge. After release with enable_in=1, the frame restarts at LED 0.
- color_valid_in toggling during SEND_HIGH/SEND_LOW with changing colour data -> transmitted bits unaffected.
